// File: rtl/vec_exec_pkg.sv
// Shared types and constants for the vector execution unit.
// Holds the op encoding, result flag bit positions and default parameter values.
// No logic here; imported by the interface, the lane ALU and the top.
package vec_exec_pkg;

  localparam int DEF_LANES = 4;
  localparam int DEF_DW    = 32;
  localparam int DEF_IMMW  = 8;

  // Codes 11..15 are undefined and execute as VAND.
  typedef enum logic [3:0] {
    VADD   = 4'd0,
    VSUB   = 4'd1,
    VMUL   = 4'd2,
    VAND   = 4'd3,
    VOR    = 4'd4,
    VXOR   = 4'd5,
    VADDI  = 4'd6,
    VSPLAT = 4'd7,
    VSCALE = 4'd8,
    VSUM   = 4'd9,
    VDOT   = 4'd10
  } vec_op_t;

  // Flag positions above the scalar field of rdata_out (bit DW + index).
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_RSVD = 3;

  function automatic logic is_reduce(input vec_op_t op);
    return (op == VSUM) || (op == VDOT);
  endfunction

endpackage

// File: rtl/vector_exec_unit_if.sv
// Handshake bundle for vector_exec_unit: operand/op request and result response.
// master = producer/consumer side (testbench or upstream), slave = the unit.
// Ports: in_valid/in_ready request handshake, out_valid/out_ready result handshake.
interface vector_exec_unit_if #(
  parameter int LANES = vec_exec_pkg::DEF_LANES,
  parameter int DW    = vec_exec_pkg::DEF_DW,
  parameter int IMMW  = vec_exec_pkg::DEF_IMMW
);

  logic                         in_valid;
  logic                         in_ready;
  logic [LANES-1:0][DW-1:0]     vdata1;
  logic [LANES-1:0][DW-1:0]     vdata2;
  logic [DW-1:0]                data1;
  logic [DW-1:0]                data2;
  logic [IMMW-1:0]              immediate;
  vec_exec_pkg::vec_op_t        op;
  logic                         out_valid;
  logic                         out_ready;
  logic [LANES-1:0][DW-1:0]     vdata_out;
  logic [DW+3:0]                rdata_out;

  modport master (
    output in_valid, vdata1, vdata2, data1, data2, immediate, op, out_ready,
    input  in_ready, out_valid, vdata_out, rdata_out
  );

  modport slave (
    input  in_valid, vdata1, vdata2, data1, data2, immediate, op, out_ready,
    output in_ready, out_valid, vdata_out, rdata_out
  );

endinterface

// File: rtl/vec_lane_alu.sv
// Purpose: one lane of the lane-wise vector ops (purely combinational).
// Latency: zero; the top registers the result on acceptance.
// Backpressure: none here; the top gates loading with its handshake.
// Ports: op select, a/b lane operands, scalar (data1), imm (already sign-extended), result.
module vec_lane_alu
  import vec_exec_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  vec_op_t       op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] scalar,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] result
);

  always_comb begin
    result = a & b;
    case (op)
      VADD:    result = a + b;
      VSUB:    result = a - b;
      VMUL:    result = a * b;
      VAND:    result = a & b;
      VOR:     result = a | b;
      VXOR:    result = a ^ b;
      VADDI:   result = a + imm;
      VSPLAT:  result = scalar;
      VSCALE:  result = a * scalar;
      default: result = a & b;  // undefined codes behave as VAND
    endcase
  end

endmodule

// File: rtl/vector_exec_unit.sv
// Purpose: vector execution unit; lane-wise ops in one cycle, VSUM/VDOT reduced one lane per cycle.
// Latency: lane-wise result 1 cycle after acceptance; reductions LANES+1 cycles after acceptance.
// Backpressure: in_ready only in IDLE with the result slot free or draining; result held while out_ready low.
// Ports: clk, rst_n (async active-low), bus (vector_exec_unit_if.slave) carrying both handshakes.
module vector_exec_unit
  import vec_exec_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int IMMW  = DEF_IMMW
) (
  input logic               clk,
  input logic               rst_n,
  vector_exec_unit_if.slave bus
);

  localparam int            CW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [DW-1:0]            acc;
  logic                     ovf_acc;
  logic                     dot_q;
  logic [LANES-1:0][DW-1:0] v1_q;
  logic [LANES-1:0][DW-1:0] v2_q;
  logic [LANES-1:0][DW-1:0] vdata_q;
  logic [DW+3:0]            rdata_q;
  logic                     out_valid_q;

  logic                     in_ready;
  logic                     accept;
  logic [DW-1:0]            imm_sext;
  logic [LANES-1:0][DW-1:0] alu_res;
  logic [DW-1:0]            lane_a;
  logic [DW-1:0]            lane_b;
  logic [DW-1:0]            term;
  logic [DW-1:0]            acc_sum;
  logic                     step_ovf;

  function automatic logic [DW+3:0] pack_rdata(input logic [DW-1:0] s, input logic ovf);
    logic [DW+3:0] r;
    r                 = '0;
    r[DW-1:0]         = s;
    r[DW + FLAG_ZERO] = (s == '0);
    r[DW + FLAG_NEG]  = s[DW-1];
    r[DW + FLAG_OVF]  = ovf;
    return r;
  endfunction

  assign in_ready = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign imm_sext = {{(DW-IMMW){bus.immediate[IMMW-1]}}, bus.immediate};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vec_lane_alu #(.DW(DW)) u_alu (
      .op     (bus.op),
      .a      (bus.vdata1[i]),
      .b      (bus.vdata2[i]),
      .scalar (bus.data1),
      .imm    (imm_sext),
      .result (alu_res[i])
    );
  end

  // Reduction step on the latched operands; overflow is a signed carry-out
  // (same-sign addends producing an opposite-sign sum).
  assign lane_a   = v1_q[cnt];
  assign lane_b   = v2_q[cnt];
  assign term     = dot_q ? lane_a * lane_b : lane_a;
  assign acc_sum  = acc + term;
  assign step_ovf = (acc[DW-1] == term[DW-1]) && (acc_sum[DW-1] != acc[DW-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      ovf_acc     <= 1'b0;
      dot_q       <= 1'b0;
      v1_q        <= '0;
      v2_q        <= '0;
      vdata_q     <= '0;
      rdata_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // Drain first; a lane-wise load below overrides this in the same cycle.
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_reduce(bus.op)) begin
              v1_q    <= bus.vdata1;
              v2_q    <= bus.vdata2;
              dot_q   <= (bus.op == VDOT);
              acc     <= bus.data2;
              ovf_acc <= 1'b0;
              cnt     <= '0;
              state   <= REDUCE;
            end else begin
              vdata_q     <= alu_res;
              rdata_q     <= pack_rdata(alu_res[0], 1'b0);
              out_valid_q <= 1'b1;
            end
          end
        end
        REDUCE: begin
          acc     <= acc_sum;
          ovf_acc <= ovf_acc | step_ovf;
          if (cnt == LAST_LANE) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // The slot is free here: accepting the reduction required it.
          vdata_q     <= v1_q;
          rdata_q     <= pack_rdata(acc, ovf_acc);
          out_valid_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.vdata_out = vdata_q;
  assign bus.rdata_out = rdata_q;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Self-checking bench for vector_exec_unit: directed steps, scoreboard of expected results.
module tb_vector_exec_unit;
  import vec_exec_pkg::*;

  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int IMMW  = 8;

  typedef logic [LANES-1:0][DW-1:0] vec_t;
  typedef struct packed {
    vec_t          v;
    logic [DW+3:0] r;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_exec_unit_if #(.LANES(LANES), .DW(DW), .IMMW(IMMW)) bus ();

  vector_exec_unit #(.LANES(LANES), .DW(DW), .IMMW(IMMW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  vec_op_t rand_ops[7] = '{VSUB, VMUL, VAND, VOR, VXOR, VSPLAT, VSCALE};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(input logic [DW-1:0] l0, l1, l2, l3);
    vec_t r;
    r[0] = l0; r[1] = l1; r[2] = l2; r[3] = l3;
    return r;
  endfunction

  function automatic logic [DW+3:0] flags(input logic [DW-1:0] s, input logic ovf);
    return {1'b0, ovf, s[DW-1], (s == 0), s};
  endfunction

  function automatic exp_t model(input vec_op_t o, input vec_t a, input vec_t b,
                                 input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                 input logic [IMMW-1:0] imm);
    exp_t          e;
    logic [DW-1:0] se;
    logic [DW-1:0] t;
    longint        acc;
    logic          ovf;
    se = DW'($signed(imm));
    if (o == VSUM || o == VDOT) begin
      acc = longint'($signed(d2));
      ovf = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        t   = (o == VDOT) ? a[i] * b[i] : a[i];
        acc = acc + longint'($signed(t));
        if (acc != longint'($signed(acc[DW-1:0]))) ovf = 1'b1;
        acc = longint'($signed(acc[DW-1:0]));
      end
      e.v = a;
      e.r = flags(acc[DW-1:0], ovf);
    end else begin
      for (int i = 0; i < LANES; i++) begin
        case (o)
          VADD:    e.v[i] = a[i] + b[i];
          VSUB:    e.v[i] = a[i] - b[i];
          VMUL:    e.v[i] = a[i] * b[i];
          VOR:     e.v[i] = a[i] | b[i];
          VXOR:    e.v[i] = a[i] ^ b[i];
          VADDI:   e.v[i] = a[i] + se;
          VSPLAT:  e.v[i] = d1;
          VSCALE:  e.v[i] = a[i] * d1;
          default: e.v[i] = a[i] & b[i];
        endcase
      end
      e.r = flags(e.v[0], 1'b0);
    end
    return e;
  endfunction

  task automatic drive(input vec_op_t o, input vec_t a, input vec_t b,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                       input logic [IMMW-1:0] imm);
    bus.op        = o;
    bus.vdata1    = a;
    bus.vdata2    = b;
    bus.data1     = d1;
    bus.data2     = d2;
    bus.immediate = imm;
    bus.in_valid  = 1'b1;
  endtask

  // Drive one op for a single edge (caller ensures in_ready) and record its expected result.
  task automatic send(input vec_op_t o, input vec_t a, input vec_t b,
                      input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                      input logic [IMMW-1:0] imm);
    drive(o, a, b, d1, d2, imm);
    exp_q.push_back(model(o, a, b, d1, d2, imm));
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Compare the presented result against the oldest expected entry.
  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 160'(exp_q.size()), 160'(1));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 160'(bus.out_valid), 160'(1));
      check({tag, "_vdata"}, 160'(bus.vdata_out), 160'(e.v));
      check({tag, "_rdata"}, 160'(bus.rdata_out), 160'(e.r));
    end
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 160'(bus.out_valid), 160'(1));
  endtask

  initial begin
    vec_t          ra, rb;
    logic [DW-1:0] rd1;
    logic          seen;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = VADD;
    bus.vdata1    = '0;
    bus.vdata2    = '0;
    bus.data1     = '0;
    bus.data2     = '0;
    bus.immediate = '0;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 160'(bus.out_valid), 160'(0));
    check("rst_vdata", 160'(bus.vdata_out), 160'(0));
    check("rst_rdata", 160'(bus.rdata_out), 160'(0));
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 160'(bus.in_ready), 160'(1));

    // VADD basic
    send(VADD, mk(1, 2, 3, 4), mk(10, 20, 30, 40), 0, 0, 0);
    check("vadd_lanes", 160'(bus.vdata_out), 160'(mk(11, 22, 33, 44)));
    check_out("vadd");

    // VADDI with negative immediate, back to back
    send(VADDI, mk(5, 5, 5, 5), mk(0, 0, 0, 0), 0, 0, 8'hFE);
    check("vaddi_lanes", 160'(bus.vdata_out), 160'(mk(3, 3, 3, 3)));
    check_out("vaddi");

    // VSUB to zero -> zero flag
    send(VSUB, mk(7, 9, 1, 2), mk(7, 9, 1, 2), 0, 0, 0);
    check_out("vsub_zero");

    // Undefined op code behaves as VAND
    send(vec_op_t'(4'd13), mk(32'hFF0F, 3, 6, 32'hFFFF_FFFF), mk(32'h0FF0, 5, 3, 32'h8000_0001), 0, 0, 0);
    check_out("undef_op");

    // Random lane-wise ops back to back
    for (int i = 0; i < 7; i++) begin
      for (int l = 0; l < LANES; l++) begin
        ra[l] = $urandom;
        rb[l] = $urandom;
      end
      rd1 = $urandom;
      send(rand_ops[i], ra, rb, rd1, 0, 8'($urandom));
      check_out($sformatf("rand_%s", rand_ops[i].name()));
    end

    // VDOT: in_ready low while reducing, result 5 cycles after acceptance
    tick();
    send(VDOT, mk(1, 2, 3, 4), mk(5, 6, 7, 8), 0, 100, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("vdot_busy%0d_in_ready", i), 160'(bus.in_ready), 160'(0));
      check($sformatf("vdot_busy%0d_out_valid", i), 160'(bus.out_valid), 160'(0));
      tick();
    end
    check("vdot_cycle4_out_valid", 160'(bus.out_valid), 160'(0));
    tick();
    check("vdot_scalar", 160'(bus.rdata_out[DW-1:0]), 160'(170));
    check_out("vdot");

    // VSUM with signed overflow
    tick();
    send(VSUM, mk(32'h7FFF_FFFF, 1, 0, 0), mk(0, 0, 0, 0), 0, 0, 0);
    wait_valid("vsum", 10);
    check("vsum_rdata_const", 160'(bus.rdata_out), 160'({4'b0110, 32'h8000_0000}));
    check_out("vsum");

    // Backpressure after VXOR: hold 3 cycles, then release accepts VOR the same edge
    tick();
    bus.out_ready = 1'b0;
    send(VXOR, mk(32'hF0F0, 1, 2, 3), mk(32'h0FF0, 3, 2, 1), 0, 0, 0);
    drive(VOR, mk(1, 2, 4, 8), mk(16, 32, 64, 128), 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_in_ready", i), 160'(bus.in_ready), 160'(0));
      check($sformatf("bp%0d_vdata", i), 160'(bus.vdata_out), 160'(exp_q[0].v));
      check($sformatf("bp%0d_rdata", i), 160'(bus.rdata_out), 160'(exp_q[0].r));
      tick();
    end
    check_out("vxor_held");
    exp_q.push_back(model(VOR, mk(1, 2, 4, 8), mk(16, 32, 64, 128), 0, 0, 0));
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 160'(bus.in_ready), 160'(1));
    tick();
    bus.in_valid = 1'b0;
    check_out("vor_after_release");

    // Reset during the second REDUCE cycle aborts the reduction
    tick();
    send(VSUM, mk(1, 2, 3, 4), mk(0, 0, 0, 0), 0, 0, 0);
    tick();
    check("abort_busy_in_ready", 160'(bus.in_ready), 160'(0));
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 160'(bus.out_valid), 160'(0));
    check("abort_idle_in_ready", 160'(bus.in_ready), 160'(1));
    check("abort_rdata", 160'(bus.rdata_out), 160'(0));
    void'(exp_q.pop_back());
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("abort_no_result", 160'(seen), 160'(0));

    // Recovery after the abort
    send(VADD, mk(100, 0, 0, 0), mk(23, 1, 1, 1), 0, 0, 0);
    check_out("vadd_after_abort");
    tick();
    check("sb_empty", 160'(exp_q.size()), 160'(0));
    check("final_out_valid", 160'(bus.out_valid), 160'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_exec_unit.md
VECTOR_EXEC_UNIT -- requirements
Module: vector_exec_unit

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning the vector lane count (2..16).
REQ-002 SHALL have parameter DW, default 32, meaning the lane and scalar data width.
REQ-003 SHALL have parameter IMMW, default 8, meaning the immediate width, sign-extended to DW.
REQ-004 SHALL have port clk, input, 1, the only clock; all state is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, meaning the operands and op are presented.
REQ-007 SHALL have port in_ready, output, 1, meaning the unit accepts on in_valid && in_ready.
REQ-008 SHALL have ports vdata1 and vdata2, input, DW x [LANES], vector operands.
REQ-009 SHALL have ports data1 and data2, input, DW, scalar operands.
REQ-010 SHALL have port immediate, input, IMMW, immediate operand.
REQ-011 SHALL have port op, input, vec_op_t, operation select.
REQ-012 SHALL have port out_valid, output, 1, meaning the result registers hold a valid result.
REQ-013 SHALL have port out_ready, input, 1, meaning the consumer accepts on out_valid && out_ready.
REQ-014 SHALL have port vdata_out, output, DW x [LANES], vector result.
REQ-015 SHALL have port rdata_out, output, DW+4, with {rsvd=0, ovf, neg, zero, scalar[DW-1:0]} from MSB down.

Function
REQ-016 SHALL implement lane-wise ops VADD, VSUB, VMUL (low DW bits), VAND, VOR, VXOR, VADDI (v1 + sext(imm)), VSPLAT (every lane = data1), VSCALE (v1[i] * data1, low DW bits).
REQ-017 SHALL implement reduction ops VSUM (sum of v1 lanes + data2) and VDOT (sum of v1[i]*v2[i] + data2); all arithmetic wraps modulo 2^DW.
REQ-018 SHALL return a lane-wise op result on vdata_out with out_valid asserted the cycle after acceptance; rdata_out scalar field = lane 0 result.
REQ-019 SHALL use FSM states IDLE, REDUCE and DONE.
REQ-020 SHALL, on a reduction, latch the operands, go from IDLE to REDUCE, process one lane per cycle from lane 0 up with a $clog2(LANES) counter, and go to DONE after lane LANES-1.
REQ-021 SHALL assert out_valid LANES+1 cycles after a reduction is accepted; vdata_out = latched v1, rdata_out scalar = accumulator.
REQ-022 SHALL set the ovf flag if any accumulate step overflows as signed (sticky per op); ovf = 0 for lane-wise ops.
REQ-023 SHALL set neg = scalar MSB and zero = (scalar == 0).
REQ-024 SHALL drive in_ready = (state == IDLE) && (!out_valid || out_ready), permitting back-to-back lane-wise ops at full rate.
REQ-025 SHALL hold the result registers stable while out_valid && !out_ready, and deassert out_valid on handshake unless a new result loads the same cycle.
REQ-026 SHALL treat an undefined op code as VAND with ovf = 0; it SHALL NOT hang.
REQ-027 SHALL ignore operand changes during REDUCE; in_ready = 0 there.

Reset
REQ-028 SHALL, with rst_n low at any time including mid-REDUCE, go to IDLE, set out_valid = 0, clear vdata_out, rdata_out, accumulator and counter to 0, and abort any operation.
REQ-029 SHALL drive in_ready = 1 on the first cycle after rst_n deasserts.

Structure
REQ-030 SHALL place vec_op_t enum, flag bit index constants and default parameter values in shared package vec_exec_pkg.
REQ-031 SHALL use one sub-module vec_lane_alu (one per lane, generate loop) for lane-wise ops; reduction datapath and FSM stay in the top.

Verification
REQ-032 SHALL cover: VADD v1={1,2,3,4}, v2={10,20,30,40} -> next cycle vdata_out={11,22,33,44}, rdata_out scalar=11, flags 0.
REQ-033 SHALL cover: VDOT v1={1,2,3,4}, v2={5,6,7,8}, data2=100 -> out_valid after 5 cycles, scalar=170, in_ready low for 4 cycles.
REQ-034 SHALL cover: VSUM v1={0x7FFFFFFF,1,0,0}, data2=0 -> scalar=0x80000000, ovf=1, neg=1.
REQ-035 SHALL cover: out_ready held low 3 cycles after VXOR result -> outputs stable, in_ready=0, then releasing accepts the next op that same cycle.
REQ-036 SHALL cover: rst_n asserted in cycle 2 of REDUCE -> immediate out_valid=0, state IDLE, no result ever emitted.
REQ-037 SHALL cover: VADDI v1 lanes=5, immediate=8'hFE -> every lane = 3.
